// File: rtl/poc_pkg.sv
// poc_pkg: shared constants, state encodings and helpers for the
// parallel-output-controller subsystem (processor model, POC, printer model).
// No ports; imported by poc_ctrl and poc_top.
package poc_pkg;

  // Register bus addresses
  localparam logic ADDR_SR = 1'b0;
  localparam logic ADDR_BR = 1'b1;

  // Status register bit positions
  localparam int FLAG = 7;  // 1 = buffer register free
  localparam int IE   = 0;  // interrupt enable

  // Processor model states
  typedef enum logic [1:0] {
    PROC_INIT,    // first cycle after reset: program SR with the mode
    PROC_IDLE,    // decide between mode write, byte write or idle read
    PROC_BR_WR,   // bus is carrying the BR write
    PROC_SR_CLR   // bus is carrying the flag-clearing SR write
  } proc_state_e;

  // POC transfer states
  typedef enum logic [1:0] {
    POC_IDLE,
    POC_WAIT,
    POC_SEND
  } poc_state_e;

  // Printer model states
  typedef enum logic {
    PRN_READY,
    PRN_BUSY
  } prn_state_e;

  // Read image of SR: only the flag and IE bits are implemented
  function automatic logic [7:0] sr_image(input logic flag, input logic ie);
    return {flag, 6'b0, ie};
  endfunction

endpackage

// File: rtl/poc_ctrl.sv
// poc_ctrl: the parallel output controller itself.
// Holds SR (flag + IE) and BR, provides the combinational read mux and the
// active-low interrupt, and runs the TR/RDY transfer FSM toward the printer.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_bus_rw            1 = write cycle on the register bus
//   i_bus_addr          0 = SR, 1 = BR
//   i_bus_wdata[7:0]    write data, applied at the edge ending the bus cycle
//   i_prn_rdy_next      printer ready value being established at this edge
//   o_rdata[7:0]        read data (combinational)
//   o_irq               active-low interrupt, ~(flag & IE)
//   o_tr                one-cycle transfer strobe (registered)
//   o_pd[7:0]           printer data (registered, holds last byte sent)
module poc_ctrl
  import poc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bus_rw,
  input  logic       i_bus_addr,
  input  logic [7:0] i_bus_wdata,
  input  logic       i_prn_rdy_next,
  output logic [7:0] o_rdata,
  output logic       o_irq,
  output logic       o_tr,
  output logic [7:0] o_pd
);

  poc_state_e state_q, state_d;
  logic       flag_q, flag_d;
  logic       ie_q, ie_d;
  logic [7:0] br_q, br_d;
  logic       tr_q, tr_d;
  logic [7:0] pd_q, pd_d;

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    ie_d    = ie_q;
    br_d    = br_q;
    tr_d    = tr_q;
    pd_d    = pd_q;

    // Bus writes. The processor may clear the flag but never set it.
    if (i_bus_rw) begin
      if (i_bus_addr == ADDR_BR) begin
        br_d = i_bus_wdata;
      end else begin
        ie_d   = i_bus_wdata[IE];
        flag_d = flag_q & i_bus_wdata[FLAG];
      end
    end

    case (state_q)
      // Leave IDLE on the same edge the flag is cleared so the strobe can
      // follow one edge later.
      POC_IDLE: if (!flag_d) state_d = POC_WAIT;
      // The printer's ready value for after this edge is used, so a byte is
      // handed over on the very edge the printer finishes the previous one.
      POC_WAIT: begin
        if (i_prn_rdy_next) begin
          pd_d    = br_q;
          tr_d    = 1'b1;
          state_d = POC_SEND;
        end
      end
      // Setting the flag here wins over any simultaneous SR write.
      POC_SEND: begin
        tr_d    = 1'b0;
        flag_d  = 1'b1;
        state_d = POC_IDLE;
      end
      default: state_d = POC_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= POC_IDLE;
      flag_q  <= 1'b1;
      ie_q    <= 1'b0;
      br_q    <= 8'h00;
      tr_q    <= 1'b0;
      pd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      ie_q    <= ie_d;
      br_q    <= br_d;
      tr_q    <= tr_d;
      pd_q    <= pd_d;
    end
  end

  assign o_rdata = (i_bus_addr == ADDR_BR) ? br_q : sr_image(flag_q, ie_q);
  assign o_irq   = ~(flag_q & ie_q);
  assign o_tr    = tr_q;
  assign o_pd    = pd_q;

endmodule

// File: rtl/poc_top.sv
// poc_top: complete POC subsystem - processor model, poc_ctrl and printer
// model - with every internal bus exported for observation.
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_data[7:0]                byte source sampled when a BR write is issued
//   i_mode                     0 = polling, 1 = interrupt
//   o_tr, o_pd[7:0]            POC -> printer strobe and data
//   o_rdy                      printer -> POC ready
//   o_data[7:0]                last byte latched by the printer
//   o_rw, o_addr               processor bus direction / address
//   o_irq                      active-low interrupt
//   o_data_poc_to_processor    read data (combinational)
//   o_data_processor_to_poc    write data
module poc_top
  import poc_pkg::*;
#(
  parameter int PRINT_CYCLES = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_mode,
  output logic       o_tr,
  output logic [7:0] o_pd,
  output logic       o_rdy,
  output logic [7:0] o_data,
  output logic       o_rw,
  output logic       o_addr,
  output logic       o_irq,
  output logic [7:0] o_data_poc_to_processor,
  output logic [7:0] o_data_processor_to_poc
);

  localparam int CNT_W = $clog2(PRINT_CYCLES + 1);

  // ---------------- processor model ----------------
  proc_state_e proc_state_q, proc_state_d;
  logic        rw_q, rw_d;
  logic        addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        mode_q, mode_d;
  logic        byte_cond;

  // In polling mode the flag is only meaningful during a genuine SR read
  // cycle; during a write cycle the mux still shows the pre-write SR.
  always_comb begin
    if (mode_q) begin
      byte_cond = ~o_irq;
    end else begin
      byte_cond = ~rw_q & (addr_q == ADDR_SR) & o_data_poc_to_processor[FLAG];
    end
  end

  always_comb begin
    proc_state_d = proc_state_q;
    mode_d       = mode_q;
    // idle bus: read of SR
    rw_d         = 1'b0;
    addr_d       = ADDR_SR;
    wdata_d      = 8'h00;

    case (proc_state_q)
      PROC_INIT: begin
        rw_d         = 1'b1;
        wdata_d      = sr_image(1'b1, i_mode);
        mode_d       = i_mode;
        proc_state_d = PROC_IDLE;
      end
      PROC_IDLE: begin
        if (i_mode != mode_q) begin
          rw_d    = 1'b1;
          wdata_d = sr_image(1'b1, i_mode);
          mode_d  = i_mode;
        end else if (byte_cond) begin
          rw_d         = 1'b1;
          addr_d       = ADDR_BR;
          wdata_d      = i_data;
          proc_state_d = PROC_BR_WR;
        end
      end
      PROC_BR_WR: begin
        rw_d         = 1'b1;
        wdata_d      = sr_image(1'b0, mode_q);
        proc_state_d = PROC_SR_CLR;
      end
      PROC_SR_CLR: proc_state_d = PROC_IDLE;
      default:     proc_state_d = PROC_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      proc_state_q <= PROC_INIT;
      rw_q         <= 1'b0;
      addr_q       <= ADDR_SR;
      wdata_q      <= 8'h00;
      mode_q       <= 1'b0;
    end else begin
      proc_state_q <= proc_state_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mode_q       <= mode_d;
    end
  end

  // ---------------- POC ----------------
  logic prn_rdy_next;

  poc_ctrl u_poc_ctrl (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_bus_rw       (rw_q),
    .i_bus_addr     (addr_q),
    .i_bus_wdata    (wdata_q),
    .i_prn_rdy_next (prn_rdy_next),
    .o_rdata        (o_data_poc_to_processor),
    .o_irq          (o_irq),
    .o_tr           (o_tr),
    .o_pd           (o_pd)
  );

  // ---------------- printer model ----------------
  prn_state_e       prn_state_q, prn_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       prn_data_q, prn_data_d;

  // Counter is loaded with PRINT_CYCLES and ready returns when it expires,
  // i.e. exactly PRINT_CYCLES edges after the byte was accepted.
  always_comb begin
    prn_state_d = prn_state_q;
    cnt_d       = cnt_q;
    prn_data_d  = prn_data_q;
    if (o_tr) begin
      prn_data_d  = o_pd;
      prn_state_d = PRN_BUSY;
      cnt_d       = CNT_W'(PRINT_CYCLES);
    end else if (prn_state_q == PRN_BUSY) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) prn_state_d = PRN_READY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prn_state_q <= PRN_READY;
      cnt_q       <= '0;
      prn_data_q  <= 8'h00;
    end else begin
      prn_state_q <= prn_state_d;
      cnt_q       <= cnt_d;
      prn_data_q  <= prn_data_d;
    end
  end

  assign prn_rdy_next = (prn_state_d == PRN_READY);

  assign o_rdy                   = (prn_state_q == PRN_READY);
  assign o_data                  = prn_data_q;
  assign o_rw                    = rw_q;
  assign o_addr                  = addr_q;
  assign o_data_processor_to_poc = wdata_q;

endmodule

// File: tb/tb_poc_top.sv
module tb_poc_top;

  localparam int P = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_mode;
  logic       o_tr, o_rdy, o_rw, o_addr, o_irq;
  logic [7:0] o_pd, o_data, o_rdata, o_wdata;

  always #5 clk = ~clk;

  poc_top #(.PRINT_CYCLES(P)) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_data                  (i_data),
    .i_mode                  (i_mode),
    .o_tr                    (o_tr),
    .o_pd                    (o_pd),
    .o_rdy                   (o_rdy),
    .o_data                  (o_data),
    .o_rw                    (o_rw),
    .o_addr                  (o_addr),
    .o_irq                   (o_irq),
    .o_data_poc_to_processor (o_rdata),
    .o_data_processor_to_poc (o_wdata)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: SR/BR register semantics, printer busy time and the
  // ordered list of bytes written to BR and still awaiting print.
  logic       m_flag = 1'b1, m_ie = 1'b0, m_rdy = 1'b1;
  logic [7:0] m_br = 8'h00, m_pd = 8'h00, m_pdata = 8'h00;
  int         m_cnt = 0;
  logic [7:0] q[$];
  int         last_tr = -1;
  int         period_exp = 0;
  logic       after_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model from pre-edge values, check outputs.
  task automatic tick();
    logic       p_rst, p_rw, p_addr, p_tr, p_irq, p_mode, p_flag;
    logic [7:0] p_wd, p_din, e;
    logic       e_irq;
    p_rst  = rst_n;  p_rw = o_rw;   p_addr = o_addr; p_tr = o_tr;
    p_irq  = o_irq;  p_mode = i_mode; p_flag = m_flag;
    p_wd   = o_wdata; p_din = i_data;
    @(posedge clk);
    #1;
    cyc++;
    if (!p_rst) begin
      m_flag = 1'b1; m_ie = 1'b0; m_br = 8'h00; m_rdy = 1'b1; m_cnt = 0;
      m_pd = 8'h00; m_pdata = 8'h00; q.delete(); after_rst = 1'b1; last_tr = -1;
      chk("rst_bus", {o_rw, o_addr, o_wdata}, 10'h000);
      chk("rst_tr", o_tr, 1'b0);
    end else begin
      if (p_rw && !p_addr) begin
        m_ie   = p_wd[0];
        m_flag = m_flag & p_wd[7];
      end
      if (p_rw && p_addr) m_br = p_wd;
      if (p_tr) m_flag = 1'b1;
      if (p_tr) begin
        chk("print_has_pending", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          m_pdata = e;
        end
        m_rdy = 1'b0;
        m_cnt = P;
        chk("tr_one_cycle", o_tr, 1'b0);
      end else if (!m_rdy) begin
        m_cnt--;
        if (m_cnt == 0) m_rdy = 1'b1;
      end
      if (after_rst) begin
        chk("init_write", {o_rw, o_addr, o_wdata}, {2'b10, 7'b1000000, p_mode});
        after_rst = 1'b0;
      end
      if (p_rw && p_addr)
        chk("sr_clear_write", {o_rw, o_addr, o_wdata}, {2'b10, 7'b0000000, p_mode});
      if (o_rw && o_addr) begin
        chk("br_data", o_wdata, p_din);
        chk("br_when_free", p_flag, 1'b1);
        if (p_mode) chk("br_after_irq", p_irq, 1'b0);
        q.push_back(p_din);
      end
      if (o_tr && !p_tr) begin
        chk("tr_pending", q.size(), 1);
        if (q.size() > 0) m_pd = q[0];
        chk("tr_printer_ready", m_rdy, 1'b1);
        chk("tr_flag_clear", m_flag, 1'b0);
        if (period_exp > 0 && last_tr >= 0) chk("tr_period", cyc - last_tr, period_exp);
        last_tr = cyc;
      end
    end
    e_irq = ~(m_flag & m_ie);
    chk("rdata", o_rdata, o_addr ? m_br : {m_flag, 6'b0, m_ie});
    chk("irq", o_irq, e_irq);
    chk("rdy", o_rdy, m_rdy);
    chk("pd", o_pd, m_pd);
    chk("printer_data", o_data, m_pdata);
    chk("no_backlog", q.size() <= 1, 1'b1);
  endtask

  initial begin
    rst_n  = 1'b0;
    i_mode = 1'b0;
    i_data = 8'h05;

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_rdata", o_rdata, 8'h80);
    chk("rst_irq", o_irq, 1'b1);
    chk("rst_rdy", o_rdy, 1'b1);
    $display("step reset: rdata=%0h irq=%0b rdy=%0b", o_rdata, o_irq, o_rdy);

    // Polling, single byte 0x05, directed latency
    rst_n = 1'b1;
    tick();
    chk("poll_init", {o_rw, o_addr, o_wdata}, {2'b10, 8'h80});
    tick();
    chk("poll_idle_read", {o_rw, o_addr}, 2'b00);
    tick();
    chk("poll_br_write", {o_rw, o_addr, o_wdata}, {2'b11, 8'h05});
    tick();
    chk("poll_sr_clear", {o_rw, o_addr, o_wdata}, {2'b10, 8'h00});
    tick();
    chk("poll_flag_clr", o_rdata, 8'h00);
    tick();
    chk("poll_tr", {o_tr, o_pd}, {1'b1, 8'h05});
    tick();
    chk("poll_print", {o_tr, o_rdy, o_data}, {2'b00, 8'h05});
    repeat (9) tick();
    chk("poll_rdy_low_10", o_rdy, 1'b0);
    tick();
    chk("poll_rdy_back", o_rdy, 1'b1);
    $display("step polling: printed=%0h", o_data);

    // Backpressure with random data: strobes 11 cycles apart
    period_exp = P + 1;
    last_tr    = -1;
    for (int k = 0; k < 80; k++) begin
      i_data = 8'($urandom);
      tick();
    end
    $display("step backpressure: last printed=%0h", o_data);

    // Mode switch 0->1 while the POC is waiting on the printer
    period_exp = 0;
    for (int k = 0; k < 40 && !(m_flag == 1'b0 && m_rdy == 1'b0 && m_cnt > 3); k++) begin
      i_data = 8'($urandom);
      tick();
    end
    chk("switch_wait_reached", {m_flag, m_rdy}, 2'b00);
    i_mode = 1'b1;
    tick();
    chk("switch_sr_write", {o_rw, o_addr, o_wdata}, {2'b10, 8'h81});
    tick();
    chk("switch_no_flag_set", o_rdata, 8'h01);
    $display("step mode switch: rdata=%0h", o_rdata);

    // Interrupt mode, random data
    for (int k = 0; k < 20; k++) begin
      i_data = 8'($urandom);
      tick();
    end
    period_exp = P + 1;
    last_tr    = -1;
    for (int k = 0; k < 60; k++) begin
      i_data = 8'($urandom);
      tick();
    end
    $display("step interrupt: last printed=%0h", o_data);

    // Reset while the printer counter is running
    period_exp = 0;
    for (int k = 0; k < 40 && !(m_rdy == 1'b0 && m_cnt > 2); k++) begin
      i_data = 8'($urandom);
      tick();
    end
    chk("midrst_busy_reached", m_rdy, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_rdy", o_rdy, 1'b1);
    chk("midrst_tr", o_tr, 1'b0);
    chk("midrst_rdata", o_rdata, 8'h80);
    chk("midrst_irq", o_irq, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("midrst_init", {o_rw, o_addr, o_wdata}, {2'b10, 8'h81});
    for (int k = 0; k < 30; k++) begin
      i_data = 8'($urandom);
      tick();
    end
    $display("step reset mid-transfer: rdy=%0b printed=%0h", o_rdy, o_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poc_top.md
# poc_top

Self-contained parallel-output-controller (POC) subsystem with three parts: a processor model, the POC, and a printer model. The processor moves bytes from `i_data` into the POC over a simple register bus. It uses polling (`i_mode`=0) or interrupts (`i_mode`=1). The POC hands each byte to the printer with a TR/RDY handshake. All internal buses are exported as outputs for observation.

## Interface
- `PRINT_CYCLES`, default 10: number of cycles the printer holds RDY low after accepting a byte (≥1).
- `i_clk` in 1: single clock; every register updates on its rising edge.
- `i_rst_n` in 1: reset is synchronous and active-low.
- `i_data` in 8: source byte; the processor samples it when it issues a BR write.
- `i_mode` in 1: 0 = polling, 1 = interrupt.
- `o_tr` out 1: POC→printer transfer strobe, one cycle.
- `o_pd` out 8: POC→printer data, registered, holds the last byte sent.
- `o_rdy` out 1: printer→POC ready.
- `o_data` out 8: last byte latched by the printer.
- `o_rw` out 1: processor bus direction, 1 = write, 0 = read.
- `o_addr` out 1: processor bus address, 0 = SR, 1 = BR.
- `o_irq` out 1: active-low interrupt, equal to ~(SR[7] & SR[0]).
- `o_data_poc_to_processor` out 8: read data, combinational. `o_addr`=0 gives {SR[7],6'b0,SR[0]}; `o_addr`=1 gives BR.
- `o_data_processor_to_poc` out 8: write data.

## Operation
**POC registers**
- SR[7] is the flag: 1 = BR free.
- SR[0] is IE.
- BR is the buffer register.

**Bus writes.** Writes are applied at the edge that ends the bus cycle.
- BR write: BR ← data.
- SR write: SR[0] ← data[0] and SR[7] ← SR[7] & data[7]. The processor can clear the flag but never set it.

**POC FSM**
- IDLE: when SR[7] goes to 0, go to WAIT.
- WAIT: at an edge where `o_rdy`=1, load `o_pd`←BR and `o_tr`←1, then go to SEND.
- SEND: at the next edge, load `o_tr`←0 and SR[7]←1, then go to IDLE.

**Printer**
- At an edge with `o_tr`=1: `o_data`←`o_pd`, `o_rdy`←0, and a counter is loaded.
- `o_rdy` returns to 1 exactly `PRINT_CYCLES` edges later.

**Processor**
- Bus outputs are registered. The idle bus value is a read of SR (rw=0, addr=0, data=0).
- INIT (after reset): issue a write to SR with 0x80|i_mode.
- IDLE, decided at each edge, with priority in this order:
  1. If `i_mode` differs from the latched mode, issue a write to SR with 0x80|i_mode and update the latched mode.
  2. Otherwise, if the byte condition holds, issue a write to BR with `i_data`. In polling mode the condition is that the sampled SR read data has bit7=1. In interrupt mode it is `o_irq`=0.
- After a BR write, the next cycle is a write to SR with {0,6'b0,mode}, which clears the flag. The processor then returns to IDLE.

## Timing
**Reset values**
- `o_tr`=0, `o_pd`=0, `o_data`=0, `o_rdy`=1.
- `o_rw`=0, `o_addr`=0, `o_data_processor_to_poc`=0.
- SR=0x80, so `o_data_poc_to_processor`=0x80 and `o_irq`=1.
- BR=0.
- Both FSMs return to their initial states (processor INIT, POC IDLE) and the printer counter clears.

**Latency**
- Let E0 be the edge where the processor sees the byte condition.
- E1: BR written. E2: flag cleared. E3: `o_tr`=1 if the printer is ready. E4: printer latches the byte, `o_rdy`=0, flag set.
- The processor loop is 5 cycles. Byte period is max(5, `PRINT_CYCLES`+1) cycles.

**Boundary conditions**
- If `o_rdy`=0 during WAIT, `o_tr` stays low until `o_rdy` returns to 1.
- No byte is lost or duplicated.
- A mode write never sets the flag.
- A mode change takes priority over a byte on the same edge.
- Reset mid-transfer restores all reset values on the next edge.

## Structure
- Package `poc_pkg` holds:
  - `ADDR_SR`=0 and `ADDR_BR`=1;
  - SR bit indices FLAG=7 and IE=0;
  - the processor, POC and printer state enums.
- One natural sub-module, `poc_ctrl`, contains the SR/BR registers, the read mux, `o_irq` and the POC FSM.
- The processor and printer models live in `poc_top`.

## Test plan
- **Reset:** hold `i_rst_n`=0 for 3 cycles → all outputs at reset values, read data 0x80, `o_irq`=1.
- **Polling, `i_mode`=0, `i_data`=0x05:**
  - bus shows INIT write of 0x80, then a BR write of 0x05, then an SR write of 0x00;
  - `o_tr` pulses for 1 cycle with `o_pd`=0x05;
  - `o_data`=0x05 and `o_rdy` is low for 10 cycles.
- **Backpressure:** change `i_data` every cycle with `PRINT_CYCLES`=10 → `o_tr` pulses are exactly 11 cycles apart and each `o_data` equals the BR value written.
- **Interrupt, `i_mode`=1:**
  - INIT write is 0x81;
  - `o_irq`=0 whenever SR[7]=1, and BR writes occur only after `o_irq`=0;
  - the SR clear write is 0x01.
- **Mode switch mid-run (0→1 while WAIT):** next processor write is SR=0x81; the pending byte still prints; the flag is not set early.
- **Reset asserted while the printer counter is running:** next edge gives `o_rdy`=1, `o_tr`=0, SR=0x80, processor INIT.
